// File: rtl/pwm_bank_if.sv
// Control/observation bundle for pwm_bank: runtime duty/period writes in, PWM outputs out.
interface pwm_bank_if #(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 20,
  parameter int CH_W   = 4
);
  logic              enable;
  logic              duty_wr;
  logic [CH_W-1:0]   duty_ch;
  logic [CNT_W-1:0]  duty_val;
  logic              period_wr;
  logic [CNT_W-1:0]  period_val;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;
  logic [CNT_W-1:0]  cnt_out;

  modport master (
    output enable, duty_wr, duty_ch, duty_val, period_wr, period_val,
    input  pwm_out, period_start, cnt_out
  );

  modport slave (
    input  enable, duty_wr, duty_ch, duty_val, period_wr, period_val,
    output pwm_out, period_start, cnt_out
  );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM with a shared period counter and double-buffered duty/period registers.
// Optional soft-start/soft-stop duty ramping is enabled by defining PWM_BANK_RAMP_EN.
module pwm_bank #(
  parameter int          NUM_CH         = 5,
  parameter int          CNT_W          = 20,
  parameter int unsigned PERIOD_DEFAULT = 999999,
  parameter int          CH_W           = 4
`ifdef PWM_BANK_RAMP_EN
  , parameter int unsigned RAMP_STEP    = 1000
`endif
) (
  input  logic      clk,
  input  logic      rst,
  pwm_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] TERM_RST = CNT_W'(PERIOD_DEFAULT);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  term_act_q, term_act_d;
  logic [CNT_W-1:0]  term_pend_q, term_pend_d;
  logic [CNT_W-1:0]  duty_act_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d  [NUM_CH];
  logic [CNT_W-1:0]  duty_pend_q [NUM_CH];
  logic [CNT_W-1:0]  duty_pend_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              period_start_q, period_start_d;
  logic              run_q, run_d;
  logic              boundary;

  // A zero terminal count would mean a 1-cycle period; floor it at a 2-cycle period.
  function automatic logic [CNT_W-1:0] clamp_term(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

`ifdef PWM_BANK_RAMP_EN
  function automatic logic [CNT_W-1:0] ramp_duty(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] step;
    step = CNT_W'(RAMP_STEP);
    if (tgt >= cur) return ((tgt - cur) > step) ? cur + step : tgt;
    else            return ((cur - tgt) > step) ? cur - step : tgt;
  endfunction
`endif

  always_comb begin
    // The first enabled cycle after a park or reset starts a fresh period.
    boundary       = bus.enable && (!run_q || (cnt_q == term_act_q));
    run_d          = bus.enable;
    period_start_d = boundary;

    if (!bus.enable || boundary) cnt_d = '0;
    else                         cnt_d = cnt_q + CNT_W'(1);

    term_act_d  = boundary ? term_pend_q : term_act_q;
    term_pend_d = bus.period_wr ? clamp_term(bus.period_val) : term_pend_q;

    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      duty_pend_d[i] = (bus.duty_wr && (bus.duty_ch == CH_W'(i))) ? bus.duty_val
                                                                  : duty_pend_q[i];
`ifdef PWM_BANK_RAMP_EN
      duty_act_d[i]  = boundary ? ramp_duty(duty_act_q[i], duty_pend_q[i]) : duty_act_q[i];
`else
      duty_act_d[i]  = boundary ? duty_pend_q[i] : duty_act_q[i];
`endif
      pwm_d[i]       = bus.enable && (cnt_d < duty_act_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      term_act_q     <= TERM_RST;
      term_pend_q    <= TERM_RST;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      run_q          <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act_q[i]  <= '0;
        duty_pend_q[i] <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      term_act_q     <= term_act_d;
      term_pend_q    <= term_pend_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      run_q          <= run_d;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_act_q[i]  <= duty_act_d[i];
        duty_pend_q[i] <= duty_pend_d[i];
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = period_start_q;
  assign bus.cnt_out      = cnt_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank; the ramp scenario runs when PWM_BANK_RAMP_EN is defined.
module tb_pwm_bank;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 20;
  localparam int CH_W   = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pwm_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  pwm_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_DEFAULT(999999), .CH_W(CH_W)
`ifdef PWM_BANK_RAMP_EN
    , .RAMP_STEP(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr_duty(input int ch, input int val);
    bus.duty_wr  = 1'b1;
    bus.duty_ch  = CH_W'(ch);
    bus.duty_val = CNT_W'(val);
    tick();
    bus.duty_wr  = 1'b0;
  endtask

  task automatic wr_period(input int val);
    bus.period_wr  = 1'b1;
    bus.period_val = CNT_W'(val);
    tick();
    bus.period_wr  = 1'b0;
  endtask

  initial begin
    int d;
    int hi;
    int exp_d [9];
    exp_d = '{2, 4, 6, 7, 7, 5, 3, 1, 0};

    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.duty_wr    = 1'b0;
    bus.duty_ch    = '0;
    bus.duty_val   = '0;
    bus.period_wr  = 1'b0;
    bus.period_val = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_cnt", int'(bus.cnt_out), 0);
    check("rst_pwm", int'(bus.pwm_out), 0);
    check("rst_ps",  int'(bus.period_start), 0);

`ifdef PWM_BANK_RAMP_EN
    wr_period(99);
    wr_duty(0, 7);
    bus.enable = 1'b1;
    tick();
    for (int p = 0; p < 9; p++) begin
      hi = 0;
      for (int c = 0; c < 100; c++) begin
        if (c == 0) begin
          check("ramp_ps",  int'(bus.period_start), 1);
          check("ramp_cnt", int'(bus.cnt_out), 0);
        end
        if (bus.pwm_out[0]) hi++;
        if (p == 4 && c == 0) wr_duty(0, 0);
        else                  tick();
      end
      check("ramp_duty", hi, exp_d[p]);
    end
`else
    // Program while parked: period 10, ch0=3, ch1=0, ch2=10 (100%), ch3=15 (>100%)
    wr_period(9);
    wr_duty(0, 3);
    wr_duty(2, 10);
    wr_duty(3, 15);
    check("parked_cnt", int'(bus.cnt_out), 0);
    check("parked_pwm", int'(bus.pwm_out), 0);

    bus.enable = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      check("t1_cnt", int'(bus.cnt_out), k % 10);
      check("t1_ps",  int'(bus.period_start), (k % 10 == 0) ? 1 : 0);
      check("t1_pwm", int'(bus.pwm_out), 12 | ((k % 10 < 3) ? 1 : 0));
      tick();
    end

    // Mid-period write of 5, then a write of 7 on the boundary cycle
    for (int k = 20; k < 24; k++) tick();
    wr_duty(0, 5);
    for (int k = 25; k < 50; k++) begin
      d = (k < 30) ? 3 : (k < 40) ? 5 : 7;
      check("t3_pwm", int'(bus.pwm_out), 12 | ((k % 10 < d) ? 1 : 0));
      if (k == 29) wr_duty(0, 7);
      else         tick();
    end

    // Park at cnt=4, rewrite ch0 while parked, then resume
    for (int k = 50; k < 54; k++) tick();
    check("t5_cnt4", int'(bus.cnt_out), 4);
    bus.enable = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      check("t5_hold_cnt", int'(bus.cnt_out), 0);
      check("t5_hold_pwm", int'(bus.pwm_out), 0);
      check("t5_hold_ps",  int'(bus.period_start), 0);
      if (j == 0) wr_duty(0, 2);
      else        tick();
    end
    bus.enable = 1'b1;
    tick();
    for (int m = 0; m < 12; m++) begin
      check("t5_cnt", int'(bus.cnt_out), m % 10);
      check("t5_ps",  int'(bus.period_start), (m % 10 == 0) ? 1 : 0);
      check("t5_pwm", int'(bus.pwm_out), 12 | ((m % 10 < 2) ? 1 : 0));
      tick();
    end

    // Period 0 clamps to a 2-cycle period; duty and period written together; bad channel ignored
    bus.period_wr  = 1'b1;
    bus.period_val = '0;
    wr_duty(0, 1);
    bus.period_wr  = 1'b0;
    wr_duty(NUM_CH, 1);
    for (int m = 14; m < 20; m++) tick();
    for (int m = 20; m < 28; m++) begin
      check("t4_cnt", int'(bus.cnt_out), m % 2);
      check("t4_ps",  int'(bus.period_start), (m % 2 == 0) ? 1 : 0);
      check("t4_pwm", int'(bus.pwm_out), 12 | ((m % 2 == 0) ? 1 : 0));
      tick();
    end

    // Reset mid-period with enable held high
    tick();
    check("t5_pre_rst_cnt", int'(bus.cnt_out), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_cnt", int'(bus.cnt_out), 0);
    check("mid_rst_pwm", int'(bus.pwm_out), 0);
    check("mid_rst_ps",  int'(bus.period_start), 0);
    rst = 1'b0;
    tick();
    check("post_rst_ps",  int'(bus.period_start), 1);
    check("post_rst_cnt", int'(bus.cnt_out), 0);
    check("post_rst_pwm", int'(bus.pwm_out), 0);
    tick();
    check("post_rst_cnt1", int'(bus.cnt_out), 1);
    check("post_rst_ps1",  int'(bus.period_start), 0);
    check("post_rst_pwm1", int'(bus.pwm_out), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Parametrised successor to the fixed-duty drive PWM generator.
- NUM_CH independent PWM channels share one period counter.
- Duty and period are programmable at runtime through a write port. New values are double-buffered and applied only at a period boundary, so no runt or glitch pulses reach the motor drivers.
- Sits between the steering/speed control FSM and the H-bridge enable pins.

Parameters:
- NUM_CH, 5, number of PWM output channels (1..16)
- CNT_W, 20, width of the period counter and of duty/period values
- PERIOD_DEFAULT, 999999, period terminal count loaded at reset (period = PERIOD_DEFAULT+1 cycles)
- CH_W, 4, width of channel index port (must satisfy 2**CH_W >= NUM_CH)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- enable  input  1  run PWM; low = counter parked, outputs low
- duty_wr  input  1  write strobe for pending duty of channel duty_ch
- duty_ch  input  CH_W  channel index for duty_wr
- duty_val  input  CNT_W  on-count (cycles high per period)
- period_wr  input  1  write strobe for pending period terminal count
- period_val  input  CNT_W  period terminal count
- pwm_out  output  NUM_CH  PWM outputs, bit i = channel i
- period_start  output  1  one-cycle pulse when a new period begins
- cnt_out  output  CNT_W  current counter value (debug/sync)

Behaviour:
- Reset (rst=1 at clk edge): cnt=0, term_act=term_pend=PERIOD_DEFAULT, all duty_act/duty_pend=0, pwm_out=0, period_start=0. Reset has priority over every other input, including mid-period.
- Counter: while enable=1, cnt increments each cycle. When cnt==term_act, cnt<=0 next cycle (the boundary). Period length = term_act+1 cycles.
- Boundary cycle (cnt==term_act, enable=1):
  - term_act<=term_pend; duty_act[i]<=duty_pend[i] for all i.
  - period_start<=1 for the following cycle (aligned with cnt==0).
- Pending-register writes:
  - duty_wr=1: duty_pend[duty_ch]<=duty_val. If duty_ch>=NUM_CH, the write is ignored.
  - period_wr=1: term_pend<=period_val. period_val==0 is clamped to 1, giving a 2-cycle minimum period.
  - Writes are accepted every cycle, regardless of enable.
- Write coinciding with the boundary: the latch takes the pre-write pending value. The new value lands in pending and applies at the next boundary. duty_wr and period_wr in the same cycle both take effect.
- Output: pwm_out[i] is registered, pwm_out[i] <= enable & (cnt_next < duty_act_next[i]), evaluated on the counter value for the coming cycle. Hence pwm_out[i]=1 exactly for cnt in [0, duty_act[i]-1].
  - duty_act=0: constantly low.
  - duty_act > term_act: constantly high (100%).
  - No glitch at the boundary when consecutive periods have equal duty.
- Enable deassert:
  - Next cycle cnt=0 and pwm_out=0; the counter holds at 0 and period_start stays 0.
  - On reassert, the first active cycle is treated as a boundary: pending values are latched, period_start pulses, and pwm_out rises for channels with duty>0.
- Arithmetic: all compares unsigned CNT_W-bit; the counter never exceeds term_act, so it cannot wrap.
- Shrinking the period below the current cnt can only happen at a boundary, so no overrun is possible.

Optional Feature:
- Macro PWM_BANK_RAMP_EN.
- Defined: adds parameter RAMP_STEP (default 1000). At each boundary, duty_act[i] moves toward duty_pend[i] by at most RAMP_STEP, both up and down, saturating exactly at the target. This gives soft-start and soft-stop for the drive motors.
- Undefined: duty_act[i] jumps directly to duty_pend[i] at the boundary, as described above.
- Period latching is unaffected in both cases.

Test Plan:
1. Reset, enable=1, period_wr val=9, duty_wr ch0=3 → after the first boundary, period = 10 cycles; pwm_out[0] high for 3 cycles, low for 7; period_start pulses every 10 cycles.
2. Duty edge cases with period=9: ch1=0, ch2=10, ch3=15 → pwm_out[1] constantly 0; pwm_out[2] and pwm_out[3] constantly 1.
3. duty_wr ch0=5 issued mid-period, then a second write ch0=7 exactly on the boundary cycle → the current period keeps the old duty; the next period shows 5; the period after shows 7.
4. period_wr val=0 → period becomes 2 cycles; duty=1 gives an alternating 1,0 pattern. duty_wr with duty_ch=NUM_CH → no channel changes.
5. Deassert enable at cnt=4, hold 3 cycles, reassert → pwm_out=0 and cnt=0 during the hold; on reassert, period_start pulses and the waveform restarts from cnt=0. Also assert rst mid-period → all outputs 0 and registers return to reset values next cycle.
6. With PWM_BANK_RAMP_EN defined and RAMP_STEP=2, period=99, duty 0→7 → successive periods show duty 2, 4, 6, 7, 7.
